// File: rtl/sprite_pkg.sv
// Shared constants for the sprite position controller: direction bit indices,
// edge-flag indices and the default coordinate type.
package sprite_pkg;

  // Bit positions within the 4-bit direction request
  localparam int unsigned DIR_LEFT  = 3;
  localparam int unsigned DIR_UP    = 2;
  localparam int unsigned DIR_DOWN  = 1;
  localparam int unsigned DIR_RIGHT = 0;

  // Bit positions within the at_edge flag vector
  localparam int unsigned EDGE_LEFT   = 3;
  localparam int unsigned EDGE_TOP    = 2;
  localparam int unsigned EDGE_BOTTOM = 1;
  localparam int unsigned EDGE_RIGHT  = 0;

  localparam int unsigned COORD_W_DFLT = 12;
  typedef logic [COORD_W_DFLT-1:0] coord_t;

endpackage

// File: rtl/axis_stepper.sv
// One axis of the sprite position: saturating step towards 0 or LIMIT on a tick,
// clamped immediate load. Optional acceleration under SPRITE_POS_ACCEL_EN.
module axis_stepper #(
  parameter int unsigned COORD_W  = 12,
  parameter int unsigned LIMIT    = 540,
  parameter int unsigned INIT     = 270,
  parameter int unsigned STEP     = 2,
  parameter int unsigned MAX_STEP = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_dec,
  input  logic               i_inc,
  input  logic               i_tick,
  input  logic               i_hold,
  input  logic               i_load,
  input  logic [COORD_W-1:0] i_load_val,
  output logic [COORD_W-1:0] o_pos
);

  localparam logic [COORD_W-1:0] Limit   = COORD_W'(LIMIT);
  localparam logic [COORD_W-1:0] InitPos = COORD_W'(INIT);
  localparam logic [COORD_W-1:0] StepV   = COORD_W'(STEP);

  if (INIT > LIMIT || STEP > MAX_STEP || LIMIT >= (1 << COORD_W)) begin : g_param_err
    $error("axis_stepper: illegal INIT/LIMIT/STEP/MAX_STEP combination");
  end

  logic [COORD_W-1:0] r_pos;
  logic [COORD_W-1:0] w_pos_nxt;
  logic [COORD_W-1:0] w_step;
  logic [COORD_W-1:0] w_diff;
  logic [COORD_W:0]   w_sum;
  logic               w_move_dec;
  logic               w_move_inc;
  logic               w_move;

  // Opposing or absent requests cancel out
  assign w_move_dec = i_dec & ~i_inc;
  assign w_move_inc = i_inc & ~i_dec;
  assign w_move     = i_tick & ~i_hold & ~i_load & (w_move_dec | w_move_inc);

  assign w_diff = r_pos - w_step;
  assign w_sum  = {1'b0, r_pos} + {1'b0, w_step};

`ifdef SPRITE_POS_ACCEL_EN
  logic [COORD_W-1:0] r_speed;
  logic [1:0]         r_last;
  logic               w_same;

  localparam logic [COORD_W-1:0] MaxStepV = COORD_W'(MAX_STEP);

  // r_last is 00 when the previous tick did not move, so a fresh start never matches
  assign w_same = (r_last == {w_move_dec, w_move_inc});
  assign w_step = w_same ? r_speed : StepV;

  // Speed ramps by one per continued tick, capped; any break in motion restarts at STEP
  always_ff @(posedge i_clk) begin
    if (i_rst || i_load || i_hold) begin
      r_speed <= StepV;
      r_last  <= 2'b00;
    end else if (i_tick) begin
      if (w_move) begin
        r_speed <= (w_step >= MaxStepV) ? MaxStepV : w_step + COORD_W'(1);
        r_last  <= {w_move_dec, w_move_inc};
      end else begin
        r_speed <= StepV;
        r_last  <= 2'b00;
      end
    end
  end
`else
  assign w_step = StepV;
`endif

  // Next position: load wins over movement; movement saturates at 0 and LIMIT
  always_comb begin
    w_pos_nxt = r_pos;
    if (i_load) begin
      w_pos_nxt = (i_load_val > Limit) ? Limit : i_load_val;
    end else if (w_move && w_move_dec) begin
      w_pos_nxt = (r_pos > w_step) ? w_diff : '0;
    end else if (w_move && w_move_inc) begin
      w_pos_nxt = (w_sum < {1'b0, Limit}) ? w_sum[COORD_W-1:0] : Limit;
    end
  end

  // Position register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pos <= InitPos;
    end else begin
      r_pos <= w_pos_nxt;
    end
  end

  assign o_pos = r_pos;

endmodule

// File: rtl/sprite_pos_ctrl.sv
// 2-D sprite position controller: tick divider, two axis steppers, edge decode.
// Optional acceleration is compiled in with `define SPRITE_POS_ACCEL_EN.
module sprite_pos_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned COORD_W    = 12,
  parameter int unsigned TICK_CNT_W = 21,
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SCREEN_H   = 480,
  parameter int unsigned SPRITE_W   = 100,
  parameter int unsigned SPRITE_H   = 100,
  parameter int unsigned X_INIT     = 270,
  parameter int unsigned Y_INIT     = 190,
  parameter int unsigned STEP       = 2,
  parameter int unsigned MAX_STEP   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [3:0]         i_dir,
  input  logic               i_hold,
  input  logic               i_load,
  input  logic [COORD_W-1:0] i_load_x,
  input  logic [COORD_W-1:0] i_load_y,
  output logic [COORD_W-1:0] o_x_begin,
  output logic [COORD_W-1:0] o_y_begin,
  output logic               o_tick,
  output logic [3:0]         o_at_edge
);

  localparam int unsigned X_MAX = SCREEN_W - SPRITE_W;
  localparam int unsigned Y_MAX = SCREEN_H - SPRITE_H;

  logic [TICK_CNT_W-1:0] r_cnt;
  logic                  r_tick;
  logic                  w_wrap;
  logic [COORD_W-1:0]    w_x;
  logic [COORD_W-1:0]    w_y;

  // Positions step in the same cycle the counter wraps, so they change with tick
  assign w_wrap = &r_cnt;

  // Free-running divider and registered tick pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= r_cnt + TICK_CNT_W'(1);
      r_tick <= w_wrap;
    end
  end

  axis_stepper #(
    .COORD_W  (COORD_W),
    .LIMIT    (X_MAX),
    .INIT     (X_INIT),
    .STEP     (STEP),
    .MAX_STEP (MAX_STEP)
  ) u_axis_x (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_dec      (i_dir[DIR_LEFT]),
    .i_inc      (i_dir[DIR_RIGHT]),
    .i_tick     (w_wrap),
    .i_hold     (i_hold),
    .i_load     (i_load),
    .i_load_val (i_load_x),
    .o_pos      (w_x)
  );

  axis_stepper #(
    .COORD_W  (COORD_W),
    .LIMIT    (Y_MAX),
    .INIT     (Y_INIT),
    .STEP     (STEP),
    .MAX_STEP (MAX_STEP)
  ) u_axis_y (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_dec      (i_dir[DIR_UP]),
    .i_inc      (i_dir[DIR_DOWN]),
    .i_tick     (w_wrap),
    .i_hold     (i_hold),
    .i_load     (i_load),
    .i_load_val (i_load_y),
    .o_pos      (w_y)
  );

  // Edge contact flags decoded straight from the position registers
  always_comb begin
    o_at_edge              = '0;
    o_at_edge[EDGE_LEFT]   = (w_x == '0);
    o_at_edge[EDGE_TOP]    = (w_y == '0);
    o_at_edge[EDGE_BOTTOM] = (w_y == COORD_W'(Y_MAX));
    o_at_edge[EDGE_RIGHT]  = (w_x == COORD_W'(X_MAX));
  end

  assign o_x_begin = w_x;
  assign o_y_begin = w_y;
  assign o_tick    = r_tick;

endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// Bench for sprite_pos_ctrl with a 16-clock tick period. Table of directed
// vectors for the constant-step build; acceleration sequence when
// SPRITE_POS_ACCEL_EN is defined.
module tb_sprite_pos_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dir;
  logic        hold;
  logic        load;
  logic [11:0] load_x;
  logic [11:0] load_y;
  logic [11:0] x_begin;
  logic [11:0] y_begin;
  logic        tick;
  logic [3:0]  at_edge;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sprite_pos_ctrl #(
    .TICK_CNT_W (4)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_dir     (dir),
    .i_hold    (hold),
    .i_load    (load),
    .i_load_x  (load_x),
    .i_load_y  (load_y),
    .o_x_begin (x_begin),
    .o_y_begin (y_begin),
    .o_tick    (tick),
    .o_at_edge (at_edge)
  );

  typedef struct {
    string      name;
    logic [3:0] dir;
    logic       hold;
    logic       ld;
    int         lx;
    int         ly;
    int         ticks;
    int         ex;
    int         ey;
    logic [3:0] ee;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits for n tick pulses, each within a bounded number of cycles
  task automatic wait_ticks(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      int budget = 40;
      do begin
        @(negedge clk);
        budget--;
      end while (!tick && budget > 0);
      if (tick) seen++;
      else break;
    end
  endtask

  // Cycles from now until tick is observed (bounded)
  task automatic cycles_to_tick(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!tick && cycles < 100);
  endtask

  task automatic do_load(input int lx, input int ly);
    load   = 1'b1;
    load_x = lx[11:0];
    load_y = ly[11:0];
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    int seen;
    if (v.ld) do_load(v.lx, v.ly);
    dir  = v.dir;
    hold = v.hold;
    wait_ticks(v.ticks, seen);
    check({v.name, " ticks"}, seen, v.ticks);
    check({v.name, " x"}, int'(x_begin), v.ex);
    check({v.name, " y"}, int'(y_begin), v.ey);
    check({v.name, " edge"}, int'(at_edge), int'(v.ee));
  endtask

  function automatic vec_t mk(input string name, input logic [3:0] d, input logic h,
                              input logic ld, input int lx, input int ly, input int t,
                              input int ex, input int ey, input logic [3:0] ee);
    vec_t v;
    v.name = name; v.dir = d; v.hold = h; v.ld = ld; v.lx = lx; v.ly = ly;
    v.ticks = t; v.ex = ex; v.ey = ey; v.ee = ee;
    return v;
  endfunction

  task automatic reset_and_check(input string tag);
    int cyc;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check({tag, " x"}, int'(x_begin), 270);
    check({tag, " y"}, int'(y_begin), 190);
    check({tag, " tick"}, int'(tick), 0);
    check({tag, " edge"}, int'(at_edge), 0);
    cycles_to_tick(cyc);
    check({tag, " first tick latency"}, cyc, 16);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; dir = '0; hold = 1'b0; load = 1'b0; load_x = '0; load_y = '0;
    @(negedge clk);
    reset_and_check("reset");

`ifndef SPRITE_POS_ACCEL_EN
    vecs.push_back(mk("left_sat",  4'b1000, 0, 0, 0,    0,    135, 0,   190, 4'b1000));
    vecs.push_back(mk("left_stay", 4'b1000, 0, 0, 0,    0,    3,   0,   190, 4'b1000));
    vecs.push_back(mk("ld1_left",  4'b1000, 0, 1, 1,    190,  1,   0,   190, 4'b1000));
    vecs.push_back(mk("diag_in",   4'b0011, 0, 1, 539,  379,  1,   540, 380, 4'b0011));
    vecs.push_back(mk("diag_stay", 4'b0011, 0, 0, 0,    0,    2,   540, 380, 4'b0011));
    vecs.push_back(mk("oppose_x",  4'b1001, 0, 1, 270,  190,  2,   270, 190, 4'b0000));
    vecs.push_back(mk("hold",      4'b0001, 1, 0, 0,    0,    5,   270, 190, 4'b0000));
    vecs.push_back(mk("oppose_y",  4'b0110, 0, 0, 0,    0,    2,   270, 190, 4'b0000));
    vecs.push_back(mk("up_left",   4'b1100, 0, 0, 0,    0,    3,   264, 184, 4'b0000));
    vecs.push_back(mk("down",      4'b0010, 0, 0, 0,    0,    1,   264, 186, 4'b0000));
    vecs.push_back(mk("ld_clamp",  4'b0000, 0, 1, 4095, 4095, 1,   540, 380, 4'b0011));
    vecs.push_back(mk("ld_zero",   4'b0000, 0, 1, 0,    0,    1,   0,   0,   4'b1100));
    vecs.push_back(mk("up_stay",   4'b0100, 0, 0, 0,    0,    2,   0,   0,   4'b1100));
    vecs.push_back(mk("dec_small", 4'b1100, 0, 1, 3,    3,    1,   1,   1,   4'b0000));
    vecs.push_back(mk("dec_to0",   4'b1100, 0, 0, 0,    0,    1,   0,   0,   4'b1100));
    vecs.push_back(mk("inc_near",  4'b0011, 0, 1, 538,  378,  1,   540, 380, 4'b0011));
    vecs.push_back(mk("right",     4'b0001, 0, 1, 100,  100,  2,   104, 100, 4'b0000));
    foreach (vecs[i]) apply(vecs[i]);
`else
    begin
      int exp_x[8] = '{2, 5, 9, 14, 20, 27, 35, 43};
      int seen;
      do_load(0, 190);
      dir = 4'b0001;
      for (int i = 0; i < 8; i++) begin
        wait_ticks(1, seen);
        check($sformatf("accel step %0d ticks", i), seen, 1);
        check($sformatf("accel step %0d x", i), int'(x_begin), exp_x[i]);
      end
      dir = 4'b1000;
      wait_ticks(1, seen);
      check("accel reverse x", int'(x_begin), 41);
      dir = 4'b0000;
    end
`endif

    // Load coinciding with a tick: load wins, movement discarded
    dir = 4'b0000; hold = 1'b0;
    cycles_to_tick(cyc);
    repeat (15) @(negedge clk);
    load = 1'b1; load_x = 12'd700; load_y = 12'd50; dir = 4'b0001;
    @(negedge clk);
    load = 1'b0;
    check("ld_tick tick", int'(tick), 1);
    check("ld_tick x", int'(x_begin), 540);
    check("ld_tick y", int'(y_begin), 50);
    repeat (15) @(negedge clk);
    load = 1'b1; load_x = 12'd100; load_y = 12'd50; dir = 4'b1100;
    @(negedge clk);
    load = 1'b0; dir = 4'b0000;
    check("ld_tick2 tick", int'(tick), 1);
    check("ld_tick2 x", int'(x_begin), 100);
    check("ld_tick2 y", int'(y_begin), 50);

    // Reset mid-operation, part way through a tick period
    repeat (5) @(negedge clk);
    reset_and_check("mid_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sprite_pos_ctrl.md
# sprite_pos_ctrl

- Parametrised 2-D sprite position controller for the VGA game datapath.
- Holds the top-left corner (`x_begin`, `y_begin`) of one sprite and steps it on a divided movement tick from a 4-bit direction input.
- Clamps the sprite inside the visible area and supports an immediate load for respawn/teleport.
- Drives the sprite renderer and collision logic; replaces the per-axis single-purpose movers.

## Interface
- `COORD_W`, 12: coordinate width, both axes.
- `TICK_CNT_W`, 21: width of the tick divider; tick period is 2^TICK_CNT_W clocks.
- `SCREEN_W`, 640 / `SCREEN_H`, 480: visible area, in pixels.
- `SPRITE_W`, 100 / `SPRITE_H`, 100: sprite size, in pixels.
- `X_INIT`, 270 / `Y_INIT`, 190: reset position.
- `STEP`, 2: base pixels per tick.
- `MAX_STEP`, 8: speed ceiling; used only with acceleration compiled in.
- `clk` in 1: system clock. One clock domain; no derived clocks.
- `rst` in 1: reset, synchronous and active-high.
- `dir` in 4: movement request; bit3 left, bit2 up, bit1 down, bit0 right. Any combination is legal.
- `hold` in 1: when 1, movement is frozen.
- `load` in 1: one-cycle request to set the position.
- `load_x` / `load_y` in COORD_W: position applied on `load`.
- `x_begin` / `y_begin` out COORD_W: sprite top-left, registered.
- `tick` out 1: one-cycle pulse each tick period.
- `at_edge` out 4: {left, top, bottom, right} contact flags. Combinational from the position registers.

## Operation
- Limits: X_MAX = SCREEN_W−SPRITE_W; Y_MAX = SCREEN_H−SPRITE_H. Minimum is 0 on both axes.
- Divider:
  - free-running TICK_CNT_W-bit counter;
  - `tick` is registered and asserts for exactly 1 clk when the counter wraps from all-ones to 0.
- Per axis, on a tick cycle with `hold`=0:
  - Only the decrement bit set (left/up): pos ← (pos > step) ? pos−step : 0.
  - Only the increment bit set (right/down): pos ← (pos+step < MAX) ? pos+step : MAX.
  - Both bits set, or neither: no change.
  - Compute in COORD_W+1 bits; no underflow or overflow at any step size.
  - X and Y update independently in the same tick, so diagonal moves are allowed.
- `load` takes priority over movement and is not tick-gated.
  - Each coordinate is clamped to [0, MAX] before it is stored.
  - Allowed while `hold`=1.
- `hold` blocks movement only. The divider keeps running and `tick` keeps pulsing.
- `at_edge` bit is 1 when the position equals that bound: left (x==0), top (y==0), bottom (y==Y_MAX), right (x==X_MAX).

## Timing
- Reset values:
  - counter 0;
  - `x_begin`=X_INIT, `y_begin`=Y_INIT;
  - `tick`=0;
  - `at_edge` follows from the init position (all 0 for the defaults);
  - speed=STEP.
- `dir` and `hold` are sampled in the clk cycle where the internal wrap occurs. The new position is visible on the clk edge on which `tick` rises (same edge).
- `load` is applied on the next edge (1-cycle latency). If `load` coincides with a tick, load wins and that tick's movement is discarded.
- `rst` asserted mid-operation restores all reset values on the next edge and restarts the divider at 0. The first tick then occurs 2^TICK_CNT_W clocks later.
- Elaboration check: X_INIT ≤ X_MAX, Y_INIT ≤ Y_MAX, STEP ≤ MAX_STEP, and both limits < 2^COORD_W.

## Configuration
- `SPRITE_POS_ACCEL_EN` defined:
  - Each axis keeps a speed register, reset to STEP.
  - On each tick where the axis moves in the same direction as the previous tick, speed ← min(speed+1, MAX_STEP), applied from the next tick.
  - Release, reversal, `hold`, `load` or reset returns speed to STEP.
- `SPRITE_POS_ACCEL_EN` undefined:
  - Step is constant STEP.
  - No speed registers; MAX_STEP is ignored.

## Structure
- Package `sprite_pkg`:
  - direction bit indices: DIR_LEFT=3, DIR_UP=2, DIR_DOWN=1, DIR_RIGHT=0;
  - coordinate typedef;
  - edge-flag index constants.
- Sub-module `axis_stepper`, instantiated twice (X, Y):
  - inputs: dec/inc request, tick enable, hold, load value/strobe;
  - owns position, saturating arithmetic and the optional speed register.
- The divider, tick register and `at_edge` decode stay in the top.

## Test plan
All scenarios use TICK_CNT_W=4 (tick every 16 clk); other parameters are at their defaults.
- Reset: after `rst` → x=270, y=190, `tick`=0, `at_edge`=0000. The first `tick` arrives 16 clk after `rst` is released.
- Saturation, left: `dir`=1000 held from x=270 → 135 ticks later x=0, `at_edge[3]`=1; x stays 0 afterwards. Then load x=1 and tick once with `dir`=1000 → x=0, no wrap.
- Saturation, right/down, diagonal: `dir`=0011 from load (539,379) → after 1 tick x=540, y=380, `at_edge`=0011; further ticks → no change.
- Opposing inputs and hold: `dir`=1001 → x unchanged. `dir`=0001 with `hold`=1 for 5 ticks → x unchanged, `tick` still pulses 5 times.
- Load precedence: `load`=1 with (700,50) on a tick cycle with `dir`=0001 → x=540 (clamped), y=50, movement discarded.
- Acceleration (macro defined): `dir`=0001 from x=0 → successive x = 2, 5, 9, 14, 20, 27, 35, 43. Reversing to `dir`=1000 → the next step is 2.
